main_memory_responder: RTL
==========================

// Module: main_memory_responder
// PURPOSE
//  Main-memory side of the cache<->memory strobe interface; the cache controller issues MStrobe/MRW.
//  Accepts one single-word read or write per strobe and holds it for a fixed wait-state latency.
//  Then returns a one-cycle MReady pulse, with read data for a read.
//  Backed by an internal word-addressed RAM; sits below the cache data/tag arrays in the memory hierarchy.
// PARAMETERS
//  ADDR_W       8   word address width; RAM depth = 2**ADDR_W words
//  DATA_W       32  data word width
//  WAIT_CYCLES  4   wait states between accepted strobe and response; legal range 0..255
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       reset, synchronous, active-high
//  MStrobe    in   1       request valid; sampled only in IDLE
//  MRW        in   1       1 = write, 0 = read (sampled with MStrobe)
//  MAddr      in   ADDR_W  word address (sampled with MStrobe)
//  MDataIn    in   DATA_W  write data (sampled with MStrobe)
//  MDataOut   out  DATA_W  read data; registered, holds until next read completes
//  MReady     out  1       one-cycle completion pulse, reads and writes
//  MBusy      out  1       high while a request is in flight (WAIT or RESP)
//  MErr       out  1       sticky protocol-error flag; present only with MEM_BUSY_ERR_EN
// BEHAVIOUR
//  Reset:
//   - state=IDLE; MReady=0, MBusy=0, MDataOut=0, wait counter=0, captured addr/data/rw=0, MErr=0.
//   - RAM contents are not reset.
//  States:
//   - IDLE: MStrobe=1 -> capture MAddr/MDataIn/MRW, load counter with WAIT_CYCLES.
//     Go to WAIT, or directly to RESP if WAIT_CYCLES==0.
//   - WAIT: counter decrements each cycle. When counter==1 at the clock edge, take the memory action on that edge:
//     write -> RAM[addr]<=data; read -> MDataOut<=RAM[addr]. Then go to RESP.
//   - RESP: MReady=1 for exactly this cycle; next state IDLE.
//   - WAIT_CYCLES==0: memory action is taken on the IDLE->RESP edge.
//  Latency:
//   - Strobe sampled at the end of cycle 0 -> MBusy=1 in cycles 1..WAIT_CYCLES+1.
//   - MReady=1 only in cycle WAIT_CYCLES+1; read data valid on MDataOut in that same cycle.
//  Handshake:
//   - MStrobe is a level sampled only in IDLE. A strobe held high through RESP is accepted again in the next IDLE cycle.
//   - The cache must drop MStrobe after one cycle.
//   - MStrobe in WAIT or RESP is ignored; the captured request is not altered.
//  Outputs:
//   - MReady, MBusy and MDataOut are registered outputs; no combinational path from inputs to outputs.
//  Back-to-back:
//   - Minimum request spacing is WAIT_CYCLES+2 cycles (one IDLE cycle between responses).
//   - A read issued immediately after a write to the same address returns the new data.
//  Reset mid-operation: the request is aborted, there is no MReady, MDataOut returns to 0.
//   - A write not yet committed (reset before the commit edge) leaves RAM unchanged.
//   - A reset asserted on the commit edge takes priority: no commit.
//  Address out of range: cannot occur, because the RAM depth is fully decoded as 2**ADDR_W.
// CONFIGURATION
//  MEM_BUSY_ERR_EN defined:
//   - Port MErr exists.
//   - MErr<=1 on any cycle where MStrobe=1 in WAIT or RESP.
//   - MErr stays set until reset; it does not affect normal operation.
//  MEM_BUSY_ERR_EN undefined:
//   - No MErr port.
//   - Strobes while busy are silently ignored.
// TESTING (defaults ADDR_W=8, DATA_W=32, WAIT_CYCLES=4 unless noted)
//  1 Reset held 2 cycles -> MReady=0, MBusy=0, MDataOut=0, MErr=0.
//  2 Write: strobe MRW=1 MAddr=0x12 MDataIn=0xDEADBEEF in cycle 0 -> MBusy=1 in cycles 1-5, MReady=1 only in cycle 5.
//  3 Read 0x12 right after test 2 -> MReady=1 and MDataOut=0xDEADBEEF in cycle 5; MDataOut holds afterwards.
//  4 Read 0x12 in cycle 0, plus a read of 0x34 strobed in cycle 2 -> only one MReady (cycle 5) with data of 0x12.
//    No second response; MErr=1 from cycle 3 when MEM_BUSY_ERR_EN is defined.
//  5 Write 0x20=0x1 completes. Then write 0x20=0x2 with reset in cycle 3 -> no MReady.
//    A later read of 0x20 returns 0x1.
//  6 WAIT_CYCLES=0: read strobe in cycle 0 -> MReady=1 with data in cycle 1.
//    A strobe held high continuously yields MReady every 2 cycles.

Source files
------------

// File: rtl/main_memory_responder.sv
// Strobe-driven main-memory responder: fixed wait states, then a one-cycle MReady.
// Define MEM_BUSY_ERR_EN to add the sticky MErr flag for strobes issued while busy.
module main_memory_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              MReady,
  output logic              MBusy
`ifdef MEM_BUSY_ERR_EN
  ,
  output logic              MErr
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [7:0] WC   = 8'(WAIT_CYCLES);

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic [7:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rw_q;
  logic              accept;
  logic              commit;
  logic [ADDR_W-1:0] act_addr;
  logic [DATA_W-1:0] act_data;
  logic              act_rw;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  assign accept = (state == IDLE) && MStrobe;

  // With zero wait states the access happens on the accept edge, straight from the inputs.
  always_comb begin
    act_addr = addr_q;
    act_data = data_q;
    act_rw   = rw_q;
    commit   = (state == WAIT) && (cnt == 8'd1);
    if (state == IDLE) begin
      act_addr = MAddr;
      act_data = MDataIn;
      act_rw   = MRW;
      commit   = accept && (WC == 8'd0);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (MStrobe) state_n = (WC == 8'd0) ? RESP : WAIT;
      WAIT: if (cnt == 8'd1) state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      addr_q   <= '0;
      data_q   <= '0;
      rw_q     <= 1'b0;
      MReady   <= 1'b0;
      MBusy    <= 1'b0;
      MDataOut <= '0;
    end else begin
      state  <= state_n;
      MReady <= (state_n == RESP);
      MBusy  <= (state_n != IDLE);
      if (accept) begin
        addr_q <= MAddr;
        data_q <= MDataIn;
        rw_q   <= MRW;
        cnt    <= WC;
      end else if (state == WAIT) begin
        cnt <= cnt - 8'd1;
      end
      if (commit && !act_rw) MDataOut <= mem[act_addr];
    end
  end

  // Reset on the commit edge wins: the write is dropped.
  always_ff @(posedge clk) begin
    if (!reset && commit && act_rw) mem[act_addr] <= act_data;
  end

`ifdef MEM_BUSY_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) MErr <= 1'b0;
    else if (MStrobe && (state != IDLE)) MErr <= 1'b1;
  end
`endif

endmodule
